// File: rtl/regbank_pkg.sv
// Shared widths, types and requester identifiers for the register-bank write-port controller.
package regbank_pkg;

    localparam int unsigned REG_AW   = 3;
    localparam int unsigned REG_DW   = 16;
    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/regbank_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted most recently wins.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e last_grant;

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (req[REQ_A] && req[REQ_B]) begin
                if (last_grant == REQ_B) gnt[REQ_A] = 1'b1;
                else                     gnt[REQ_B] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               last_grant <= REQ_B;
        else if (gnt[REQ_A])   last_grant <= REQ_A;
        else if (gnt[REQ_B])   last_grant <= REQ_B;
    end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Register-bank write-port controller: round-robin A/B writeback into a registered output stage.
// Optional issue scoreboard enabled by defining REGBANK_SCOREBOARD_EN.
module regbank_wb_ctrl
    import regbank_pkg::*;
#(
    parameter int unsigned REG_AW   = regbank_pkg::REG_AW,
    parameter int unsigned REG_DW   = regbank_pkg::REG_DW,
    parameter int unsigned NUM_REGS = regbank_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [REG_AW-1:0]   a_addr,
    input  logic [REG_DW-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [REG_AW-1:0]   b_addr,
    input  logic [REG_DW-1:0]   b_data,
    output logic                rb_wr,
    output logic [REG_AW-1:0]   rb_wr_addr,
    output logic [REG_DW-1:0]   rb_in,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_dst,
    input  logic [REG_AW-1:0]   iss_src0,
    input  logic [REG_AW-1:0]   iss_src1,
    output logic                iss_stall,
    output logic [NUM_REGS-1:0] busy
);

    logic [1:0] gnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid, a_valid}),
        .gnt (gnt)
    );

    assign a_ready = gnt[REQ_A];
    assign b_ready = gnt[REQ_B];

    // Bank never back-pressures, so the output stage reloads every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_wr      <= 1'b0;
            rb_wr_addr <= '0;
            rb_in      <= '0;
        end else begin
            rb_wr <= |gnt;
            if (gnt[REQ_A]) begin
                rb_wr_addr <= a_addr;
                rb_in      <= a_data;
            end else if (gnt[REQ_B]) begin
                rb_wr_addr <= b_addr;
                rb_in      <= b_data;
            end
        end
    end

`ifdef REGBANK_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        iss_stall = 1'b0;
        if (!rst && iss_valid)
            iss_stall = busy_q[iss_src0] | busy_q[iss_src1] | busy_q[iss_dst];
    end

    // Clear applied before set; the same index cannot hit both since a busy dst stalls.
    always_comb begin
        busy_d = busy_q;
        if (rb_wr)
            busy_d[rb_wr_addr] = 1'b0;
        if (iss_valid && !iss_stall)
            busy_d[iss_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_dst, iss_src0, iss_src1};
    assign iss_stall  = 1'b0;
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Directed self-checking bench for regbank_wb_ctrl; expectations follow REGBANK_SCOREBOARD_EN.
module tb_regbank_wb_ctrl;

`ifdef REGBANK_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        rb_wr;
    logic [2:0]  rb_wr_addr;
    logic [15:0] rb_in;
    logic        iss_valid;
    logic [2:0]  iss_dst, iss_src0, iss_src1;
    logic        iss_stall;
    logic [7:0]  busy;

    logic [15:0] bank [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_wb_ctrl #(.REG_AW(3), .REG_DW(16), .NUM_REGS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .rb_wr      (rb_wr),
        .rb_wr_addr (rb_wr_addr),
        .rb_in      (rb_in),
        .iss_valid  (iss_valid),
        .iss_dst    (iss_dst),
        .iss_src0   (iss_src0),
        .iss_src1   (iss_src1),
        .iss_stall  (iss_stall),
        .busy       (busy)
    );

    // Behavioural register bank fed by the write port.
    always @(posedge clk) if (rb_wr) bank[rb_wr_addr] <= rb_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = '0;
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        iss_valid = 1'b0; iss_dst = '0; iss_src0 = '0; iss_src1 = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_rb_wr", rb_wr, 0);
        check("rst_addr", rb_wr_addr, 0);
        check("rst_in", rb_in, 0);
        check("rst_busy", busy, 0);

        // Contention: reset priority is B, so A wins the first tie.
        a_valid = 1'b1; a_addr = 3'd1; a_data = 16'd1;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 16'd10;
        #1;
        check("tie1_a_ready", a_ready, 1);
        check("tie1_b_ready", b_ready, 0);
        tick();
        a_data = 16'd2;
        check("tie1_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd1, 16'd1});
        check("tie2_b_ready", b_ready, 1);
        check("tie2_a_ready", a_ready, 0);
        tick();
        b_data = 16'd20;
        check("tie2_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd2, 16'd10});
        check("tie3_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        check("tie3_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd1, 16'd2});
        check("tie4_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        check("tie4_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd2, 16'd20});
        tick();
        check("idle_rb_wr", rb_wr, 0);
        check("idle_hold_in", rb_in, 16'd20);
        check("bank_r1", bank[1], 16'd2);
        check("bank_r2", bank[2], 16'd20);

        // Single requester A: r3 = 0x1234.
        a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
        #1;
        check("single_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("single_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd3, 16'h1234});
        tick();
        check("single_bank_r3", bank[3], 16'h1234);
        check("single_drain", rb_wr, 0);

        // Ordering: B->r5=7, then A->r5=9.
        b_valid = 1'b1; b_addr = 3'd5; b_data = 16'd7;
        #1;
        check("ord_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 3'd5; a_data = 16'd9;
        #1;
        check("ord_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check("ord_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, {1'b1, 13'd0, 3'd5, 16'd9});
        tick();
        check("ord_bank_r5", bank[5], 16'd9);

        // Last grant was A, so the next tie goes to B.
        a_valid = 1'b1; a_addr = 3'd0; a_data = 16'hAAAA;
        b_valid = 1'b1; b_addr = 3'd7; b_data = 16'hBBBB;
        #1;
        check("tie_b_first", {a_ready, b_ready}, 2'b01);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("tie_b_out", {rb_wr_addr, rb_in}, {3'd7, 16'hBBBB});
        tick();

        // Scoreboard hazard sequence.
        iss_valid = 1'b1; iss_dst = 3'd4; iss_src0 = 3'd0; iss_src1 = 3'd0;
        #1;
        check("sb_issue_free", iss_stall, 0);
        tick();
        check("sb_busy4", busy, SB ? 8'h10 : 8'h00);
        iss_dst = 3'd1; iss_src0 = 3'd4;
        #1;
        check("sb_raw_stall", iss_stall, SB);
        tick();
        check("sb_stall_hold", iss_stall, SB);
        check("sb_busy_hold", busy, SB ? 8'h10 : 8'h00);
        a_valid = 1'b1; a_addr = 3'd4; a_data = 16'h00AA;
        tick();
        a_valid = 1'b0;
        check("sb_commit_out", {rb_wr, rb_wr_addr}, {1'b1, 3'd4});
        check("sb_stall_commit", iss_stall, SB);
        iss_dst = 3'd6; iss_src0 = 3'd0;
        #1;
        check("sb_r6_free", iss_stall, 0);
        tick();
        check("sb_same_edge", busy, SB ? 8'h40 : 8'h00);
        check("sb_bank_r4", bank[4], 16'h00AA);
        iss_dst = 3'd1; iss_src0 = 3'd4;
        #1;
        check("sb_r4_released", iss_stall, 0);
        iss_src0 = 3'd0; iss_src1 = 3'd6;
        #1;
        check("sb_src1_stall", iss_stall, SB);
        iss_valid = 1'b0;
        #1;
        check("sb_no_valid", iss_stall, 0);

        // Reset mid-stream with a write in the output stage.
        a_valid = 1'b1; a_addr = 3'd7; a_data = 16'h0055;
        tick();
        check("mid_rb_wr", rb_wr, 1);
        rst = 1'b1;
        iss_valid = 1'b1; iss_src1 = 3'd6;
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_iss_stall", iss_stall, 0);
        tick(); tick();
        rst = 1'b0;
        a_valid = 1'b0; iss_valid = 1'b0;
        #1;
        check("mid_rst_out", {rb_wr, 13'd0, rb_wr_addr, rb_in}, 32'd0);
        check("mid_rst_busy", busy, 0);
        tick();
        check("post_rst_no_write", rb_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_wb_ctrl.md
# regbank_wb_ctrl

Write-port controller for the 8×16 register bank. It shares the bank's single write port between two writeback requesters: A is ALU writeback and B is memory/load writeback. Arbitration is round-robin, and each accepted write passes through a registered output stage. An optional scoreboard tracks destinations with writes in flight and stalls issue on hazards. The block sits between the execute/memory stages and the bank's `wr`/`wr_addr`/`in` pins.

## Interface
Parameters:
- `REG_AW`, 3: register address width.
- `REG_DW`, 16: register data width.
- `NUM_REGS`, 8: number of registers, equal to 2**REG_AW.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: requester A has a write.
- `a_ready` out 1: A's write is accepted this cycle.
- `a_addr` in REG_AW: A's destination register.
- `a_data` in REG_DW: A's write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as the A ports, for requester B.
- `rb_wr` out 1: to the bank's `wr`; registered.
- `rb_wr_addr` out REG_AW: to the bank's `wr_addr`; registered.
- `rb_in` out REG_DW: to the bank's `in`; registered.
- `iss_valid` in 1: an instruction is issuing this cycle.
- `iss_dst` in REG_AW: issuing instruction's destination register.
- `iss_src0` in REG_AW: issuing instruction's first source register.
- `iss_src1` in REG_AW: issuing instruction's second source register.
- `iss_stall` out 1: issue must hold; combinational.
- `busy` out NUM_REGS: scoreboard bits, one per register.

## Operation
- Valid/ready handshake: a transfer occurs when `x_valid && x_ready` is high at a rising edge. Requesters hold addr/data stable while valid is high and not yet accepted.
- Ready signals are combinational from the valids and the priority state. At most one ready is high per cycle.
- The output stage drains every cycle because the bank always accepts. No back-pressure comes from the bank.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester not granted most recently.
  - Neither valid: grant nothing; the priority state holds.
- Priority state `last_grant` updates only on a grant. Reset value is B, so A wins the first tie.
- On a grant, the next rising edge loads `rb_wr`=1, `rb_wr_addr`=granted addr, `rb_in`=granted data. With no grant, `rb_wr` is 0 next cycle and addr/data hold their old values.
- A and B writes to the same address in consecutive grants reach the bank in grant order.
- Scoreboard, only when `REGBANK_SCOREBOARD_EN` is defined:
  - `iss_stall` = `iss_valid && (busy[iss_src0] | busy[iss_src1] | busy[iss_dst])`.
  - Set: `busy[iss_dst]` is set at the edge where `iss_valid && !iss_stall`.
  - Clear: `busy[rb_wr_addr]` is cleared at the edge where `rb_wr`=1, i.e. the same edge the bank commits.
  - Set and clear of different indices at the same edge: both take effect.
  - Set and clear of the same index cannot occur, because a busy destination stalls issue.
  - There is no bypass: a register stays busy through its commit cycle. The bank's combinational read reflects the new value from the following cycle.
- Register 0 gets no special treatment.

## Timing
- Reset values: `rb_wr`=0, `rb_wr_addr`=0, `rb_in`=0, `busy`=0, `last_grant`=B.
- While `rst` is high, `a_ready`, `b_ready` and `iss_stall` are all 0.
- Reset mid-operation: an in-flight output-stage write is dropped (`rb_wr` is 0 after the reset edge) and all busy bits clear.
- Latency: acceptance at edge N → bank write at edge N+1.
- Throughput: one write per cycle.
- Worst-case wait for a continuously valid requester: 1 cycle.
- `iss_stall` is combinational from `iss_*`, `busy`, and nothing else. There are no combinational paths from a/b into `iss_stall`.

## Configuration
- `REGBANK_SCOREBOARD_EN` defined: scoreboard is present as described above.
- Macro undefined:
  - No scoreboard flops.
  - `busy` is tied to 0 and `iss_stall` is tied to 0.
  - `iss_*` inputs are ignored.
  - Arbitration and the output stage are unchanged.

## Structure
- Package `regbank_pkg` holds: `REG_AW`, `REG_DW`, `NUM_REGS`, typedef `reg_addr_t`, typedef `reg_data_t`, and an enum `req_id_e` {REQ_A, REQ_B}.
- Sub-module `rr_arb2`: a 2-way round-robin arbiter.
  - Ports: `clk`, `rst`, `req[1:0]`, `gnt[1:0]`.
  - Holds `last_grant`.
  - Instantiated once.

## Test plan
- Reset: assert `rst` for 2 cycles mid-stream with `rb_wr`=1 → after release, all outputs are at reset values, `busy`=0, and no bank write occurs.
- Single requester: A writes r3=0x1234 → `a_ready`=1 in the same cycle; next cycle `rb_wr`=1, `rb_wr_addr`=3, `rb_in`=0x1234; the bank's r3 reads 0x1234 the following cycle.
- Contention: A and B both held valid for 4 cycles (A→r1 values 1,2; B→r2 values 10,20) → grants alternate A,B,A,B; the bank ends with r1=2, r2=20.
- Ordering: B→r5=7 granted, then A→r5=9 → the bank ends with r5=9.
- Scoreboard hazard (macro on):
  - Issue dst=4 → `busy[4]`=1.
  - Issue src0=4 → `iss_stall`=1 until the cycle after `rb_wr` with `rb_wr_addr`=4, then 0.
  - Same-edge set of r6 and clear of r4 → `busy`=8'b0100_0000.
- Macro off: the same issue sequence gives `iss_stall`=0 and `busy`=0 throughout, and the write traffic is identical to the macro-on run.
